// File: rtl/fp_special_pkg.sv
// Shared encodings and constant builders for the FP special-operand resolver.
package fp_special_pkg;

  typedef enum logic [1:0] {
    CLS_FIN  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  typedef enum logic [1:0] {
    KIND_ZERO = 2'd0,
    KIND_INF  = 2'd1,
    KIND_QNAN = 2'd2
  } fp_kind_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Result is right-aligned in 64 bits; callers cast down to their own width.
  function automatic logic [63:0] fp_const(input int unsigned exp_w, input int unsigned man_w,
                                           input logic sgn, input fp_kind_e kind);
    logic [63:0] man_mask;
    logic [63:0] exp_mask;
    logic [63:0] sgn_bit;
    man_mask = (64'd1 << man_w) - 64'd1;
    exp_mask = ((64'd1 << exp_w) - 64'd1) << man_w;
    sgn_bit  = 64'd1 << (exp_w + man_w);
    unique case (kind)
      KIND_QNAN: fp_const = exp_mask | man_mask;
      KIND_INF:  fp_const = exp_mask | (sgn ? sgn_bit : 64'd0);
      default:   fp_const = sgn ? sgn_bit : 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/fp_class_unit.sv
// Combinational IEEE754 operand classifier; subnormals classify as finite.
module fp_class_unit
  import fp_special_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] man,
  output fp_cls_e          cls,
  output logic             snan
);

  logic exp_ones;
  logic exp_zero;
  logic man_zero;

  assign exp_ones = &exp;
  assign exp_zero = ~|exp;
  assign man_zero = ~|man;

  always_comb begin
    cls = CLS_FIN;
    if (exp_ones) begin
      cls = man_zero ? CLS_INF : CLS_NAN;
    end else if (exp_zero && man_zero) begin
      cls = CLS_ZERO;
    end
  end

  assign snan = exp_ones && !man_zero && !man[MAN_W-1];

endmodule

// File: rtl/fp_special_resolve_pipe.sv
// Two-stage special-operand resolver for FP MUL/DIV results with sticky exception flags.
// Optional FP_NAN_PROPAGATE_EN: NaN results carry the first NaN operand, quieted.
module fp_special_resolve_pipe
  import fp_special_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_tmp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_invalid,
  output logic         out_divzero,
  input  logic         flag_clr,
  output logic         flag_invalid,
  output logic         flag_divzero
);

  localparam logic [W-1:0] QNAN     = W'(fp_const(EXP_W, MAN_W, 1'b0, KIND_QNAN));
  localparam logic [W-1:0] INF_MAG  = W'(fp_const(EXP_W, MAN_W, 1'b0, KIND_INF));
  localparam logic [W-1:0] ZERO_MAG = W'(fp_const(EXP_W, MAN_W, 1'b0, KIND_ZERO));

  fp_cls_e cls_a, cls_b;
  logic    snan_a, snan_b;

  fp_class_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
    .exp  (in_a[W-2:MAN_W]),
    .man  (in_a[MAN_W-1:0]),
    .cls  (cls_a),
    .snan (snan_a)
  );

  fp_class_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
    .exp  (in_b[W-2:MAN_W]),
    .man  (in_b[MAN_W-1:0]),
    .cls  (cls_b),
    .snan (snan_b)
  );

  logic         s1_valid, s1_op, s1_sgn, s1_snan;
  logic [W-1:0] s1_tmp;
  fp_cls_e      s1_ca, s1_cb;
  logic         s2_adv, s1_load;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign s1_load  = in_valid && in_ready;

`ifdef FP_NAN_PROPAGATE_EN
  logic [W-1:0] nan_src;
  logic [W-1:0] s1_nan;
  logic [W-1:0] quiet_bit;
  assign quiet_bit = W'(1) << (MAN_W - 1);
  assign nan_src   = ((cls_a == CLS_NAN) ? in_a : in_b) | quiet_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_nan <= '0;
    end else if (s1_load) begin
      s1_nan <= nan_src;
    end
  end
`else
  logic [W-1:0] s1_nan;
  assign s1_nan = QNAN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MUL;
      s1_sgn   <= 1'b0;
      s1_snan  <= 1'b0;
      s1_tmp   <= '0;
      s1_ca    <= CLS_FIN;
      s1_cb    <= CLS_FIN;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= in_op;
        s1_sgn  <= in_a[W-1] ^ in_b[W-1];
        s1_snan <= snan_a || snan_b;
        s1_tmp  <= in_tmp;
        s1_ca   <= cls_a;
        s1_cb   <= cls_b;
      end
    end
  end

  logic         za, zb, ia, ib, any_nan, is_mul;
  logic [W-1:0] inf_s, zero_s, res_d;
  logic         inv_d, dz_d;

  assign za      = (s1_ca == CLS_ZERO);
  assign zb      = (s1_cb == CLS_ZERO);
  assign ia      = (s1_ca == CLS_INF);
  assign ib      = (s1_cb == CLS_INF);
  assign any_nan = (s1_ca == CLS_NAN) || (s1_cb == CLS_NAN);
  assign is_mul  = (s1_op == OP_MUL);
  assign inf_s   = {s1_sgn, INF_MAG[W-2:0]};
  assign zero_s  = {s1_sgn, ZERO_MAG[W-2:0]};

  // Priority chain: NaN, invalid forms, infinities, div-by-zero, zeros, finite.
  always_comb begin
    res_d = s1_tmp;
    inv_d = 1'b0;
    dz_d  = 1'b0;
    if (any_nan) begin
      res_d = s1_nan;
      inv_d = s1_snan;
    end else if (is_mul ? ((za && ib) || (ia && zb)) : ((za && zb) || (ia && ib))) begin
      res_d = QNAN;
      inv_d = 1'b1;
    end else if (is_mul ? (ia || ib) : ia) begin
      res_d = inf_s;
    end else if (!is_mul && ib) begin
      res_d = zero_s;
    end else if (!is_mul && zb) begin
      res_d = inf_s;
      dz_d  = 1'b1;
    end else if (is_mul ? (za || zb) : za) begin
      res_d = zero_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_invalid <= 1'b0;
      out_divzero <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= res_d;
        out_invalid <= inv_d;
        out_divzero <= dz_d;
      end
    end
  end

  logic out_hs;
  assign out_hs = out_valid && out_ready;

  // A setting handshake overrides a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_invalid <= 1'b0;
      flag_divzero <= 1'b0;
    end else begin
      flag_invalid <= (flag_invalid && !flag_clr) || (out_hs && out_invalid);
      flag_divzero <= (flag_divzero && !flag_clr) || (out_hs && out_divzero);
    end
  end

endmodule
